conv_fprop1_mul_arbiter: RTL and testbench

- Shares one pipelined 31u×32s→58 multiplier instance (registered output, ce-gated, 1 cycle latency) among NUM_REQ requesters in the conv_fprop1 datapath.
- Grants round-robin, at most one operand pair per cycle.
- Carries the requester id through a tag pipeline matched to the multiplier latency, and routes each product back to its requester.
- Stalls the whole multiplier pipe through ce when the destination requester is not ready.

---
 rtl/conv_fprop1_mul_arbiter.sv | 150 +++++++++++++++
 tb/tb_conv_fprop1_mul_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_fprop1_mul_arbiter.sv
// Purpose     : round-robin share of one pipelined 31u x 32s -> 58 multiplier among NUM_REQ requesters.
// Latency     : request accepted at cycle t returns its product at t+MUL_LAT (no stalls), 1 product/cycle.
// Backpressure: an unready owner of the output product freezes the whole pipe via mul_ce; req_ready drops to 0.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   req_valid/ready   per-requester operand handshake (req_ready is at most one-hot)
//   req_a / req_b     packed operands, requester i at [i*A_W +: A_W] / [i*B_W +: B_W]
//   rsp_valid/ready   one-hot product valid, per-requester accept
//   rsp_data/rsp_id   shared product bus and the id of its owner
//   mul_ce/din0/din1  drive the external multiplier; mul_dout is its registered product
//   issue_cnt         free-running count of accepted requests (wraps at 2^32)
module conv_fprop1_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int MUL_LAT = 1,
   parameter int A_W     = 31,
   parameter int B_W     = 32,
   parameter int P_W     = 58
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [P_W-1:0]         rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   mul_ce,
   output logic [A_W-1:0]         mul_din0,
   output logic [B_W-1:0]         mul_din1,
   input  logic [P_W-1:0]         mul_dout,
   output logic [31:0]            issue_cnt
);

   // Tag pipeline: one {valid, id} per multiplier register stage.
   // Stage MUL_LAT-1 lines up with mul_dout and forms the output stage.
   logic [MUL_LAT-1:0]           r_tag_vld;
   logic [MUL_LAT-1:0][ID_W-1:0] r_tag_id;
   logic [ID_W-1:0]              r_rr_ptr;
   logic [31:0]                  r_issue_cnt;

   logic                         w_last_vld;
   logic [ID_W-1:0]              w_last_id;
   logic                         w_last_rdy;
   logic                         w_stall;
   logic                         w_gnt_en;
   logic                         w_gnt_vld;
   logic [ID_W-1:0]              w_gnt_id;
   logic [ID_W:0]                w_scan_idx;
   logic                         w_take;
   logic [ID_W-1:0]              w_next_ptr;

   assign w_last_vld = r_tag_vld[MUL_LAT-1];
   assign w_last_id  = r_tag_id[MUL_LAT-1];

   // Ready of the requester that owns the product currently at the output.
   always_comb begin
      w_last_rdy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_last_id == ID_W'(i)) begin
            w_last_rdy = rsp_ready[i];
         end
      end
   end

   // A product nobody takes freezes every stage, including the multiplier
   // itself, so the product and its tag stay aligned.
   assign w_stall = w_last_vld & ~w_last_rdy;
   assign mul_ce  = ~w_stall;

   // Granting is also blocked while reset is held so req_ready reads 0
   // immediately on assertion, without waiting for a clock edge.
   assign w_gnt_en = mul_ce & reset;

   // Round-robin scan starting at r_rr_ptr. Offsets are visited from the far
   // end back to offset 0 so the nearest valid requester is the last writer.
   always_comb begin
      w_gnt_vld  = 1'b0;
      w_gnt_id   = '0;
      w_scan_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_scan_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (w_scan_idx >= (ID_W+1)'(NUM_REQ)) begin
            w_scan_idx = w_scan_idx - (ID_W+1)'(NUM_REQ);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((w_scan_idx == (ID_W+1)'(i)) && req_valid[i]) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = ID_W'(i);
            end
         end
      end
   end

   assign w_take     = w_gnt_en & w_gnt_vld;
   assign w_next_ptr = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

   // Operand mux and per-requester accept. Operands are zero when idle.
   always_comb begin
      req_ready = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_take && (w_gnt_id == ID_W'(i))) begin
            req_ready[i] = 1'b1;
            mul_din0     = req_a[i*A_W +: A_W];
            mul_din1     = req_b[i*B_W +: B_W];
         end
      end
   end

   // Output stage: one-hot valid from the last tag, data straight from the multiplier.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = w_last_vld & (w_last_id == ID_W'(i));
      end
   end

   assign rsp_id    = w_last_id;
   assign rsp_data  = mul_dout;
   assign issue_cnt = r_issue_cnt;

   // Tag pipe, pointer and counter advance only with mul_ce so they stay in
   // lockstep with the multiplier registers. Reset drops all in-flight tags;
   // the multiplier keeps clocking (mul_ce=1) and its garbage is masked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag_vld   <= '0;
         r_tag_id    <= '0;
         r_rr_ptr    <= '0;
         r_issue_cnt <= '0;
      end else if (mul_ce) begin
         r_tag_vld[0] <= w_take;
         r_tag_id[0]  <= w_gnt_id;
         for (int s = 1; s < MUL_LAT; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_id[s]  <= r_tag_id[s-1];
         end
         if (w_take) begin
            r_rr_ptr    <= w_next_ptr;
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_conv_fprop1_mul_arbiter.sv
// Purpose     : directed self-checking bench for conv_fprop1_mul_arbiter with a product scoreboard.
// Latency     : models the external multiplier as one ce-gated register stage.
// Backpressure: drives rsp_ready patterns to exercise pipe-wide stalls.
module tb_conv_fprop1_mul_arbiter;

   localparam int NREQ = 4;

   typedef struct {
      logic [1:0]  id;
      logic [57:0] p;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*31-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [57:0]        rsp_data;
   logic [1:0]         rsp_id;
   logic               mul_ce;
   logic [30:0]        mul_din0;
   logic [31:0]        mul_din1;
   logic [57:0]        mul_dout = '0;
   logic [31:0]        issue_cnt;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   conv_fprop1_mul_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .mul_ce    (mul_ce),
      .mul_din0  (mul_din0),
      .mul_din1  (mul_din1),
      .mul_dout  (mul_dout),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   // External multiplier: single registered stage, clock-enabled.
   always @(posedge clk) begin
      if (mul_ce) mul_dout <= $signed({1'b0, mul_din0}) * $signed(mul_din1);
   end

   function automatic logic [57:0] prod(input logic [30:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      sa = {33'd0, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
      return p[57:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [30:0] a, input logic [31:0] b);
      req_a[i*31 +: 31] = a;
      req_b[i*32 +: 32] = b;
   endtask

   // Scoreboard monitor, sampled mid-cycle: compare/pop the product on the
   // output, then push the expected product of any request accepted this cycle.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
      end else begin
         chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
         if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               chk("stale_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               mon_e = exp_q[0];
               chk("sb_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << mon_e.id));
               chk("sb_rsp_id", 64'(rsp_id), 64'(mon_e.id));
               chk("sb_rsp_data", 64'(rsp_data), 64'(mon_e.p));
               if (rsp_ready[mon_e.id]) void'(exp_q.pop_front());
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_q.push_back('{id: 2'(i), p: prod(req_a[i*31 +: 31], req_b[i*32 +: 32])});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          acc_n;
      logic        acc;
      logic [57:0] e58;

      reset     = 1'b0;
      rsp_ready = 4'hF;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) set_op(i, 31'(100 + i), 32'(-(i + 1)));
      req_valid = 4'hF;

      // Reset state, with every requester asking
      tick();
      tick();
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_mul_ce", 64'(mul_ce), 64'd1);
      chk("reset_issue_cnt", 64'(issue_cnt), 64'd0);
      req_valid = '0;
      #2 reset = 1'b1;
      tick();

      // Single request from requester 1: 3 * -5
      set_op(1, 31'd3, -32'sd5);
      req_valid = 4'b0010;
      #1 chk("t1_req_ready", 64'(req_ready), 64'b0010);
      tick();
      req_valid = '0;
      e58 = '0 - 58'd15;
      #1;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("t1_rsp_id", 64'(rsp_id), 64'd1);
      chk("t1_rsp_data", 64'(rsp_data), 64'(e58));
      chk("t1_issue_cnt", 64'(issue_cnt), 64'd1);

      // Requester 3 alone moves the pointer back to 0
      set_op(3, 31'd11, 32'd13);
      req_valid = 4'b1000;
      #1 chk("pre2_req_ready", 64'(req_ready), 64'b1000);
      tick();

      // All requesters valid: grants 0,1,2,3,0,1
      for (int i = 0; i < NREQ; i++) set_op(i, 31'(200 + i), 32'(-(10 * i) - 3));
      req_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t2_req_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         chk("t2_rsp_id", 64'(rsp_id), 64'((k + 3) % 4));
         tick();
         set_op(k % 4, 31'(1000 + 37 * k), 32'(7 * k - 20));
      end
      req_valid = '0;
      #1 chk("t2_issue_cnt", 64'(issue_cnt), 64'd8);

      // Requester 2 product held back for 3 cycles
      rsp_ready = 4'b1011;
      set_op(2, 31'd100, -32'sd7);
      req_valid = 4'b0100;
      #1 chk("t3_req_ready", 64'(req_ready), 64'b0100);
      tick();
      req_valid = 4'hF;
      e58 = '0 - 58'd700;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_mul_ce", 64'(mul_ce), 64'd0);
         chk("t3_req_ready", 64'(req_ready), 64'd0);
         chk("t3_rsp_data", 64'(rsp_data), 64'(e58));
         chk("t3_rsp_valid", 64'(rsp_valid), 64'b0100);
         tick();
      end
      rsp_ready = 4'hF;
      #1;
      chk("t3_release_ready", 64'(req_ready), 64'b1000);
      chk("t3_release_ce", 64'(mul_ce), 64'd1);
      tick();
      req_valid = '0;

      // Operand extremes
      set_op(0, 31'h4000_0000, 32'h0800_0000);
      req_valid = 4'b0001;
      #1 chk("t4_req_ready0", 64'(req_ready), 64'b0001);
      tick();
      req_valid = '0;
      #1 chk("t4_big", 64'(rsp_data), 64'(58'h200000000000000));
      set_op(1, 31'h7FFF_FFFF, 32'hFFFF_FFFF);
      req_valid = 4'b0010;
      #1 chk("t4_req_ready1", 64'(req_ready), 64'b0010);
      tick();
      req_valid = '0;
      #1 chk("t4_neg", 64'(rsp_data), 64'(58'h3FFFFFF80000001));

      // Requester 0 with alternating rsp_ready: accepts at k=0,1,3,5,7,9
      set_op(0, 31'd500, -32'sd3);
      req_valid = 4'b0001;
      acc_n = 0;
      for (int k = 0; k < 10; k++) begin
         rsp_ready = {3'b111, 1'(k % 2)};
         #2 acc = req_ready[0];
         tick();
         if (acc) begin
            acc_n++;
            set_op(0, 31'(500 + acc_n), 32'(-3 - acc_n));
         end
      end
      req_valid = '0;
      rsp_ready = 4'hF;
      tick();
      tick();
      chk("t6_accepts", 64'(acc_n), 64'd6);
      chk("t6_drained", 64'(exp_q.size()), 64'd0);
      chk("t6_issue_cnt", 64'(issue_cnt), 64'd18);

      // Reset while a product is in flight
      set_op(2, 31'd9, 32'd9);
      req_valid = 4'b0100;
      #1 chk("t5_req_ready", 64'(req_ready), 64'b0100);
      tick();
      req_valid = '0;
      #1 chk("t5_pre_rsp_valid", 64'(rsp_valid), 64'b0100);
      #1 reset = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
      chk("t5_rst_mul_ce", 64'(mul_ce), 64'd1);
      chk("t5_rst_issue_cnt", 64'(issue_cnt), 64'd0);
      req_valid = '0;
      tick();
      tick();
      #1 reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1 chk("t5_no_stale", 64'(rsp_valid), 64'd0);
         tick();
      end
      for (int i = 0; i < NREQ; i++) set_op(i, 31'(300 + i), 32'(i + 5));
      req_valid = 4'hF;
      #1 chk("t5_rr_restart", 64'(req_ready), 64'b0001);
      tick();
      set_op(2, 31'd7, 32'd7);
      req_valid = 4'b0100;
      #1 chk("t5_req_ready2", 64'(req_ready), 64'b0100);
      tick();
      req_valid = '0;
      #1;
      chk("t5_rsp_valid", 64'(rsp_valid), 64'b0100);
      chk("t5_rsp_id", 64'(rsp_id), 64'd2);
      chk("t5_rsp_data", 64'(rsp_data), 64'd49);
      chk("t5_issue_cnt", 64'(issue_cnt), 64'd2);

      tick();
      tick();
      chk("end_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
